kmap_sweep_ctrl: RTL and testbench

KMAP_SWEEP_CTRL -- requirements
Module: kmap_sweep_ctrl

---
 rtl/kmap_sweep_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_kmap_sweep_ctrl.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kmap_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : kmap_sweep_ctrl
//  Purpose  : Sweeps all 16 input vectors of a 4-input logic block, waits a
//             configurable settle time per vector, then captures two
//             responses (SOP and POS realisations) into 16-bit truth tables
//             and tracks where and how often they disagree.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SETTLE_CYCLES  wait cycles per vector before sampling (0..15)
//  Ports
//    clk            sole clock, rising edge
//    rst            synchronous active-high reset
//    start          begin a sweep (only looked at in IDLE)
//    abort          terminate a sweep in progress
//    a, b, c, d     vector to the logic under test, a is the MSB
//    out_sop        SOP response of the logic under test
//    out_pos        POS response of the logic under test
//    busy           high while settling or sampling
//    done           one-cycle pulse when a sweep completes
//    truth_sop      captured SOP truth table, bit i <-> {a,b,c,d} = i
//    truth_pos      captured POS truth table, bit i <-> {a,b,c,d} = i
//    mismatch       sticky: SOP and POS disagreed at some sampled vector
//    mismatch_idx   first vector at which they disagreed
//    mismatch_cnt   number of disagreeing vectors (0..16)
// ============================================================================
module kmap_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    input  logic        out_sop,
    input  logic        out_pos,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_sop,
    output logic [15:0] truth_pos,
    output logic        mismatch,
    output logic [3:0]  mismatch_idx,
    output logic [4:0]  mismatch_cnt
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETTLE = 2'd1;
    localparam logic [1:0] c_ST_SAMPLE = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    // With no settle time every vector goes straight to SAMPLE.
    localparam logic [1:0] c_ST_FIRST  = (SETTLE_CYCLES > 0) ? c_ST_SETTLE : c_ST_SAMPLE;

    // Wait-counter value seen on the last SETTLE cycle of a vector.
    localparam int         c_SETTLE_LAST_I = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam logic [3:0] c_SETTLE_LAST   = c_SETTLE_LAST_I[3:0];

    logic [1:0]  r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_wcnt;
    logic [15:0] r_truth_sop;
    logic [15:0] r_truth_pos;
    logic        r_mismatch;
    logic [3:0]  r_mismatch_idx;
    logic [4:0]  r_mismatch_cnt;

    logic [1:0]  w_state_nxt;
    logic [3:0]  w_idx_nxt;
    logic [3:0]  w_wcnt_nxt;
    logic [15:0] w_truth_sop_nxt;
    logic [15:0] w_truth_pos_nxt;
    logic        w_mismatch_nxt;
    logic [3:0]  w_mismatch_idx_nxt;
    logic [4:0]  w_mismatch_cnt_nxt;
    logic        w_busy;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_ST_IDLE;
            r_idx          <= 4'd0;
            r_wcnt         <= 4'd0;
            r_truth_sop    <= 16'h0000;
            r_truth_pos    <= 16'h0000;
            r_mismatch     <= 1'b0;
            r_mismatch_idx <= 4'd0;
            r_mismatch_cnt <= 5'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_idx          <= w_idx_nxt;
            r_wcnt         <= w_wcnt_nxt;
            r_truth_sop    <= w_truth_sop_nxt;
            r_truth_pos    <= w_truth_pos_nxt;
            r_mismatch     <= w_mismatch_nxt;
            r_mismatch_idx <= w_mismatch_idx_nxt;
            r_mismatch_cnt <= w_mismatch_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and result update
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt        = r_state;
        w_idx_nxt          = r_idx;
        w_wcnt_nxt         = r_wcnt;
        w_truth_sop_nxt    = r_truth_sop;
        w_truth_pos_nxt    = r_truth_pos;
        w_mismatch_nxt     = r_mismatch;
        w_mismatch_idx_nxt = r_mismatch_idx;
        w_mismatch_cnt_nxt = r_mismatch_cnt;

        case (r_state)
            c_ST_IDLE: begin
                // abort beats start: nothing is launched when both are high
                if (start && !abort) begin
                    w_truth_sop_nxt    = 16'h0000;
                    w_truth_pos_nxt    = 16'h0000;
                    w_mismatch_nxt     = 1'b0;
                    w_mismatch_idx_nxt = 4'd0;
                    w_mismatch_cnt_nxt = 5'd0;
                    w_idx_nxt          = 4'd0;
                    w_wcnt_nxt         = 4'd0;
                    w_state_nxt        = c_ST_FIRST;
                end
            end

            c_ST_SETTLE: begin
                if (abort) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_wcnt_nxt = r_wcnt + 4'd1;
                    if (r_wcnt == c_SETTLE_LAST) begin
                        w_state_nxt = c_ST_SAMPLE;
                    end
                end
            end

            c_ST_SAMPLE: begin
                // An abort in this cycle drops the sample; earlier bits stay.
                if (abort) begin
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_truth_sop_nxt[r_idx] = out_sop;
                    w_truth_pos_nxt[r_idx] = out_pos;
                    if (out_sop != out_pos) begin
                        w_mismatch_cnt_nxt = r_mismatch_cnt + 5'd1;
                        if (!r_mismatch) begin
                            w_mismatch_nxt     = 1'b1;
                            w_mismatch_idx_nxt = r_idx;
                        end
                    end
                    if (r_idx == 4'd15) begin
                        // last vector: finish rather than wrap idx to 0
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_idx_nxt   = r_idx + 4'd1;
                        w_wcnt_nxt  = 4'd0;
                        w_state_nxt = c_ST_FIRST;
                    end
                end
            end

            c_ST_DONE: begin
                // start and abort are both ignored here
                w_state_nxt = c_ST_IDLE;
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_busy       = (r_state == c_ST_SETTLE) || (r_state == c_ST_SAMPLE);
    assign busy         = w_busy;
    assign done         = (r_state == c_ST_DONE);
    assign {a, b, c, d} = w_busy ? r_idx : 4'b0000;
    assign truth_sop    = r_truth_sop;
    assign truth_pos    = r_truth_pos;
    assign mismatch     = r_mismatch;
    assign mismatch_idx = r_mismatch_idx;
    assign mismatch_cnt = r_mismatch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_kmap_sweep_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kmap_sweep_ctrl
//  Purpose  : Self-checking bench for kmap_sweep_ctrl. Two instances are
//             used: u_dut1 with SETTLE_CYCLES=1 and u_dut0 with
//             SETTLE_CYCLES=0. Each instance drives a behavioural model of
//             the logic under test: out_sop = F[vec], out_pos = F[vec] ^
//             flip[vec]. Expected sweep results are pushed to a queue when a
//             sweep is launched and popped when done is seen.
//             Cycle numbering: cycle 1 is the cycle right after the edge
//             that accepts start.
//  Revision : 1.0  initial release
// ============================================================================
module tb_kmap_sweep_ctrl;

    typedef struct {
        logic [15:0] sop;
        logic [15:0] pos;
        logic        mm;
        logic [3:0]  idx;
        logic [4:0]  cnt;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start1, abort1, start0, abort0;
    logic [15:0] f_tt, pos_flip;

    // SETTLE_CYCLES = 1 instance
    logic        a1, b1, c1, d1, busy1, done1, mm1;
    logic [15:0] ts1, tp1;
    logic [3:0]  mi1;
    logic [4:0]  mc1;
    logic [3:0]  v1;
    logic        sop1, pos1;
    assign v1   = {a1, b1, c1, d1};
    assign sop1 = f_tt[v1];
    assign pos1 = f_tt[v1] ^ pos_flip[v1];

    // SETTLE_CYCLES = 0 instance
    logic        a0, b0, c0, d0, busy0, done0, mm0;
    logic [15:0] ts0, tp0;
    logic [3:0]  mi0;
    logic [4:0]  mc0;
    logic [3:0]  v0;
    logic        sop0, pos0;
    assign v0   = {a0, b0, c0, d0};
    assign sop0 = f_tt[v0];
    assign pos0 = f_tt[v0] ^ pos_flip[v0];

    kmap_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .abort(abort1),
        .a(a1), .b(b1), .c(c1), .d(d1), .out_sop(sop1), .out_pos(pos1),
        .busy(busy1), .done(done1), .truth_sop(ts1), .truth_pos(tp1),
        .mismatch(mm1), .mismatch_idx(mi1), .mismatch_cnt(mc1)
    );

    kmap_sweep_ctrl #(.SETTLE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .abort(abort0),
        .a(a0), .b(b0), .c(c0), .d(d0), .out_sop(sop0), .out_pos(pos0),
        .busy(busy0), .done(done0), .truth_sop(ts0), .truth_pos(tp0),
        .mismatch(mm0), .mismatch_idx(mi0), .mismatch_cnt(mc0)
    );

    // ------------------------------------------------------------------
    // Stimulus helpers (no comparisons in here)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_expected(input logic [15:0] f, input logic [15:0] flip,
                                          input int cycles);
        exp_t e;
        e.sop    = f;
        e.pos    = f ^ flip;
        e.mm     = 1'b0;
        e.idx    = 4'd0;
        e.cnt    = 5'd0;
        e.cycles = cycles;
        for (int i = 0; i < 16; i++) begin
            if (flip[i]) begin
                if (!e.mm) begin
                    e.mm  = 1'b1;
                    e.idx = 4'(i);
                end
                e.cnt = e.cnt + 5'd1;
            end
        end
        sb.push_back(e);
    endfunction

    // Launch a sweep on u_dut1; returns observing cycle 1.
    task automatic start_sweep1();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
    endtask

    // Wait (bounded) for done1; cyc is the cycle number in which done is seen.
    task automatic wait_done1(input int c0, output int cyc);
        cyc = c0;
        while (!done1 && cyc < 200) begin
            tick();
            cyc++;
        end
    endtask

    task automatic wait_vec1(input logic [3:0] v, output bit found);
        int n = 0;
        while (!(busy1 && v1 == v) && n < 100) begin
            tick();
            n++;
        end
        found = busy1 && (v1 == v);
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({v1, busy1, done1, ts1, tp1, mm1, mi1, mc1} !== 48'h0)
            $display("FAIL reset_dut1: got vec=%h busy=%b done=%b sop=%h pos=%h mm=%b idx=%0d cnt=%0d want all zero",
                     v1, busy1, done1, ts1, tp1, mm1, mi1, mc1);
        else n_pass++;
        n_checks++;
        if ({v0, busy0, done0, ts0, tp0, mm0, mi0, mc0} !== 48'h0)
            $display("FAIL reset_dut0: got vec=%h busy=%b done=%b sop=%h pos=%h mm=%b idx=%0d cnt=%0d want all zero",
                     v0, busy0, done0, ts0, tp0, mm0, mi0, mc0);
        else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_clean_sweep();
        exp_t e;
        int   cyc;
        f_tt     = 16'hA5C3;
        pos_flip = 16'h0000;
        push_expected(f_tt, pos_flip, 33);
        start_sweep1();
        n_checks++;
        if ({busy1, v1} !== 5'b1_0000)
            $display("FAIL clean_first_vec: got busy=%b vec=%h want busy=1 vec=0", busy1, v1);
        else n_pass++;
        wait_done1(1, cyc);
        e = sb.pop_front();
        n_checks++;
        if (cyc !== e.cycles)
            $display("FAIL clean_done_cycle: got %0d want %0d", cyc, e.cycles);
        else n_pass++;
        n_checks++;
        if ({ts1, tp1, mm1, mi1, mc1} !== {e.sop, e.pos, e.mm, e.idx, e.cnt})
            $display("FAIL clean_results: got sop=%h pos=%h mm=%b idx=%0d cnt=%0d want sop=%h pos=%h mm=%b idx=%0d cnt=%0d",
                     ts1, tp1, mm1, mi1, mc1, e.sop, e.pos, e.mm, e.idx, e.cnt);
        else n_pass++;
        tick();
        n_checks++;
        if ({done1, busy1} !== 2'b00)
            $display("FAIL clean_done_pulse: got done=%b busy=%b want 0 0", done1, busy1);
        else n_pass++;
        repeat (3) tick();
        n_checks++;
        if ({ts1, tp1, mm1, mi1, mc1} !== {e.sop, e.pos, e.mm, e.idx, e.cnt})
            $display("FAIL clean_hold: got sop=%h pos=%h want sop=%h pos=%h", ts1, tp1, e.sop, e.pos);
        else n_pass++;
    endtask

    task automatic test_mismatch();
        exp_t e;
        int   cyc;
        f_tt     = 16'hA5C3;
        pos_flip = 16'h0220;
        push_expected(f_tt, pos_flip, 33);
        start_sweep1();
        wait_done1(1, cyc);
        e = sb.pop_front();
        n_checks++;
        if (cyc !== e.cycles)
            $display("FAIL mismatch_done_cycle: got %0d want %0d", cyc, e.cycles);
        else n_pass++;
        n_checks++;
        if ({ts1, tp1, mm1, mi1, mc1} !== {e.sop, e.pos, e.mm, e.idx, e.cnt})
            $display("FAIL mismatch_results: got sop=%h pos=%h mm=%b idx=%0d cnt=%0d want sop=%h pos=%h mm=%b idx=%0d cnt=%0d",
                     ts1, tp1, mm1, mi1, mc1, e.sop, e.pos, e.mm, e.idx, e.cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_settle0();
        exp_t e;
        int   cyc, busy_cnt, vec_bad;
        f_tt     = 16'h5AA5;
        pos_flip = 16'h8000;
        push_expected(f_tt, pos_flip, 17);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        cyc      = 1;
        busy_cnt = 0;
        vec_bad  = 0;
        while (!done0 && cyc < 100) begin
            if (busy0) begin
                busy_cnt++;
                if (v0 !== 4'(cyc - 1)) vec_bad++;
            end
            tick();
            cyc++;
        end
        e = sb.pop_front();
        n_checks++;
        if (cyc !== e.cycles)
            $display("FAIL s0_done_cycle: got %0d want %0d", cyc, e.cycles);
        else n_pass++;
        n_checks++;
        if (busy_cnt !== 16)
            $display("FAIL s0_busy_cycles: got %0d want 16", busy_cnt);
        else n_pass++;
        n_checks++;
        if (vec_bad !== 0)
            $display("FAIL s0_vector_step: got %0d bad cycles want 0", vec_bad);
        else n_pass++;
        n_checks++;
        if ({ts0, tp0, mm0, mi0, mc0} !== {e.sop, e.pos, e.mm, e.idx, e.cnt})
            $display("FAIL s0_results: got sop=%h pos=%h mm=%b idx=%0d cnt=%0d want sop=%h pos=%h mm=%b idx=%0d cnt=%0d",
                     ts0, tp0, mm0, mi0, mc0, e.sop, e.pos, e.mm, e.idx, e.cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_abort();
        bit found;
        int dcnt;
        f_tt     = 16'hA5C3;
        pos_flip = 16'h0000;
        start_sweep1();
        wait_vec1(4'd7, found);
        n_checks++;
        if (!found) $display("FAIL abort_reach_vec7: got vec=%h want 7", v1);
        else n_pass++;
        tick();            // SAMPLE cycle of vector 7
        abort1 = 1'b1;
        tick();
        abort1 = 1'b0;
        n_checks++;
        if ({busy1, done1, v1} !== 6'b0)
            $display("FAIL abort_idle: got busy=%b done=%b vec=%h want 0 0 0", busy1, done1, v1);
        else n_pass++;
        n_checks++;
        if ({ts1, tp1} !== {f_tt & 16'h007F, f_tt & 16'h007F})
            $display("FAIL abort_partial: got sop=%h pos=%h want %h", ts1, tp1, f_tt & 16'h007F);
        else n_pass++;
        dcnt = 0;
        repeat (40) begin
            tick();
            if (done1 || busy1) dcnt++;
        end
        n_checks++;
        if (dcnt !== 0) $display("FAIL abort_no_done: got %0d active cycles want 0", dcnt);
        else n_pass++;
    endtask

    task automatic test_start_midsweep();
        exp_t e;
        int   cyc;
        f_tt     = 16'h1E78;
        pos_flip = 16'h0001;
        push_expected(f_tt, pos_flip, 33);
        start_sweep1();
        repeat (9) tick();   // now in cycle 10
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        wait_done1(11, cyc);
        e = sb.pop_front();
        n_checks++;
        if (cyc !== e.cycles)
            $display("FAIL midstart_done_cycle: got %0d want %0d", cyc, e.cycles);
        else n_pass++;
        n_checks++;
        if ({ts1, tp1, mm1, mi1, mc1} !== {e.sop, e.pos, e.mm, e.idx, e.cnt})
            $display("FAIL midstart_results: got sop=%h pos=%h mm=%b idx=%0d cnt=%0d want sop=%h pos=%h mm=%b idx=%0d cnt=%0d",
                     ts1, tp1, mm1, mi1, mc1, e.sop, e.pos, e.mm, e.idx, e.cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_start_abort_idle();
        int bcnt;
        start1 = 1'b1;
        abort1 = 1'b1;
        tick();
        start1 = 1'b0;
        abort1 = 1'b0;
        bcnt = 0;
        repeat (5) begin
            if (busy1 || done1) bcnt++;
            tick();
        end
        n_checks++;
        if (bcnt !== 0) $display("FAIL start_abort_idle: got %0d active cycles want 0", bcnt);
        else n_pass++;
    endtask

    task automatic test_reset_midsweep();
        exp_t e;
        bit   found;
        int   cyc, dcnt;
        f_tt     = 16'hA5C3;
        pos_flip = 16'h0220;
        start_sweep1();
        wait_vec1(4'd10, found);
        n_checks++;
        if (!found) $display("FAIL rstmid_reach_vec10: got vec=%h want a", v1);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({v1, busy1, done1, ts1, tp1, mm1, mi1, mc1} !== 48'h0)
            $display("FAIL rstmid_outputs: got vec=%h busy=%b done=%b sop=%h pos=%h mm=%b idx=%0d cnt=%0d want all zero",
                     v1, busy1, done1, ts1, tp1, mm1, mi1, mc1);
        else n_pass++;
        dcnt = 0;
        repeat (40) begin
            tick();
            if (done1 || busy1) dcnt++;
        end
        n_checks++;
        if (dcnt !== 0) $display("FAIL rstmid_no_done: got %0d active cycles want 0", dcnt);
        else n_pass++;
        push_expected(f_tt, pos_flip, 33);
        start_sweep1();
        wait_done1(1, cyc);
        e = sb.pop_front();
        n_checks++;
        if ({cyc, ts1, tp1, mm1, mi1, mc1} !== {e.cycles, e.sop, e.pos, e.mm, e.idx, e.cnt})
            $display("FAIL rstmid_fresh_sweep: got cyc=%0d sop=%h pos=%h mm=%b idx=%0d cnt=%0d want cyc=%0d sop=%h pos=%h mm=%b idx=%0d cnt=%0d",
                     cyc, ts1, tp1, mm1, mi1, mc1, e.cycles, e.sop, e.pos, e.mm, e.idx, e.cnt);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   cyc;
        f_tt     = 16'h3C5A;
        pos_flip = 16'h8001;
        push_expected(f_tt, pos_flip, 33);
        start_sweep1();
        wait_done1(1, cyc);
        e = sb.pop_front();
        n_checks++;
        if ({cyc, ts1, tp1, mm1, mi1, mc1} !== {e.cycles, e.sop, e.pos, e.mm, e.idx, e.cnt})
            $display("FAIL b2b_first: got cyc=%0d sop=%h pos=%h mm=%b idx=%0d cnt=%0d want cyc=%0d sop=%h pos=%h mm=%b idx=%0d cnt=%0d",
                     cyc, ts1, tp1, mm1, mi1, mc1, e.cycles, e.sop, e.pos, e.mm, e.idx, e.cnt);
        else n_pass++;
        // start held high from the DONE cycle: ignored there, taken in IDLE
        start1 = 1'b1;
        tick();
        n_checks++;
        if ({busy1, done1} !== 2'b00)
            $display("FAIL b2b_done_ignores_start: got busy=%b done=%b want 0 0", busy1, done1);
        else n_pass++;
        f_tt     = 16'h0FF0;
        pos_flip = 16'h0000;
        push_expected(f_tt, pos_flip, 33);
        tick();
        start1 = 1'b0;
        n_checks++;
        if ({busy1, v1, mm1, mc1} !== {1'b1, 4'd0, 1'b0, 5'd0})
            $display("FAIL b2b_second_start: got busy=%b vec=%h mm=%b cnt=%0d want 1 0 0 0", busy1, v1, mm1, mc1);
        else n_pass++;
        wait_done1(1, cyc);
        e = sb.pop_front();
        n_checks++;
        if ({cyc, ts1, tp1, mm1, mi1, mc1} !== {e.cycles, e.sop, e.pos, e.mm, e.idx, e.cnt})
            $display("FAIL b2b_second: got cyc=%0d sop=%h pos=%h mm=%b idx=%0d cnt=%0d want cyc=%0d sop=%h pos=%h mm=%b idx=%0d cnt=%0d",
                     cyc, ts1, tp1, mm1, mi1, mc1, e.cycles, e.sop, e.pos, e.mm, e.idx, e.cnt);
        else n_pass++;
        tick();
    endtask

    initial begin
        rst      = 1'b1;
        start1   = 1'b0;
        abort1   = 1'b0;
        start0   = 1'b0;
        abort0   = 1'b0;
        f_tt     = 16'h0000;
        pos_flip = 16'h0000;
        test_reset();
        test_clean_sweep();
        test_mismatch();
        test_settle0();
        test_abort();
        test_start_midsweep();
        test_start_abort_idle();
        test_reset_midsweep();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
